axil_cmd_master: RTL

- Single-outstanding AXI4-Lite master sitting directly upstream of the EthernetLite MAC wrapper; drives its s_axi_* slave port.
- Converts a simple valid/ready command stream (read or write, address, data, strobe) into one AXI4-Lite transaction.
- Returns a valid/ready response carrying read data and the AXI response code.
- Lets firmware-less control logic (TX/RX buffer access, MDIO register access) operate the MAC.

---
 rtl/axil_cmd_master.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_cmd_master.sv
// Purpose     : single-outstanding AXI4-Lite master; turns one cmd beat into one AXI-Lite read or write.
// Latency     : cmd accept at cycle 0, AW/W or AR valid at 1, rsp_valid 3 cycles after accept with a zero-wait slave.
// Backpressure: cmd_ready low from accept until rsp is consumed; rsp_valid/payload held until rsp_ready.
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   cmd_valid/ready, cmd_write,
//   cmd_addr/wdata/wstrb         - command stream (write=1, read=0)
//   rsp_valid/ready, rsp_rdata,
//   rsp_resp                     - response stream (rdata zero for writes, resp 2'b11 on timeout)
//   busy                         - high whenever a command is in progress
//   m_axi_aw*/w*/b*/ar*/r*       - AXI4-Lite master channels
//   timeout_flag                 - sticky watchdog indication (timeout build only)
//
// Build option: define AXIL_CMD_MASTER_TIMEOUT_EN to enable the per-transaction watchdog
// (P_TIMEOUT_CYCLES) and the timeout_flag port. Without it the master waits indefinitely.

module axil_cmd_master #(
   parameter int unsigned P_AXI_ADDR_WIDTH = 32,
   parameter int unsigned P_AXI_DATA_WIDTH = 32,
   parameter int unsigned P_TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            rst,
   // command stream
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_write,
   input  logic [P_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [P_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [P_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   // response stream
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [P_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic                            busy,
   // AXI4-Lite write address
   output logic [P_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic                            m_axi_awvalid,
   input  logic                            m_axi_awready,
   // AXI4-Lite write data
   output logic [P_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [P_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                            m_axi_wvalid,
   input  logic                            m_axi_wready,
   // AXI4-Lite write response
   input  logic [1:0]                      m_axi_bresp,
   input  logic                            m_axi_bvalid,
   output logic                            m_axi_bready,
   // AXI4-Lite read address
   output logic [P_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic                            m_axi_arvalid,
   input  logic                            m_axi_arready,
   // AXI4-Lite read data
   input  logic [P_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                      m_axi_rresp,
   input  logic                            m_axi_rvalid,
   output logic                            m_axi_rready
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
   ,
   output logic                            timeout_flag
`endif
);

   localparam int unsigned LP_STRB_WIDTH = P_AXI_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_DATA,
      ST_RSP
   } state_t;

   // Captured command payload; the read/write direction lives in the state itself.
   typedef struct packed {
      logic [P_AXI_ADDR_WIDTH-1:0] addr;
      logic [P_AXI_DATA_WIDTH-1:0] wdata;
      logic [LP_STRB_WIDTH-1:0]    wstrb;
   } cmd_t;

   state_t state;
   cmd_t   cmd_q;
   logic   aw_done;
   logic   w_done;
   logic   aw_hs;
   logic   w_hs;
   logic   tmo_hit;

   // Payloads come straight from the capture register, so they are stable while valid.
   assign m_axi_awaddr = cmd_q.addr;
   assign m_axi_araddr = cmd_q.addr;
   assign m_axi_wdata  = cmd_q.wdata;
   assign m_axi_wstrb  = cmd_q.wstrb;

   assign busy  = (state != ST_IDLE);
   assign aw_hs = m_axi_awvalid && m_axi_awready;
   assign w_hs  = m_axi_wvalid  && m_axi_wready;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
   localparam int unsigned LP_TMO_W = $clog2(P_TIMEOUT_CYCLES + 1);

   logic [LP_TMO_W-1:0] tmo_cnt;
   logic                tmo_active;

   assign tmo_active = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                       (state == ST_RD_REQ) || (state == ST_RD_DATA);

   // The counter holds the number of waiting cycles already spent; the watchdog
   // fires on the P_TIMEOUT_CYCLES-th waiting cycle.
   assign tmo_hit = tmo_active && (tmo_cnt == LP_TMO_W'(P_TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt      <= '0;
         timeout_flag <= 1'b0;
      end else begin
         if (state == ST_IDLE && cmd_valid) begin
            tmo_cnt <= '0;
         end else if (tmo_active) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (tmo_hit) begin
            timeout_flag <= 1'b1;
         end
      end
   end
`else
   // Watchdog compiled out: the master waits for the slave indefinitely and
   // P_TIMEOUT_CYCLES has no effect.
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         cmd_ready     <= 1'b1;
         cmd_q         <= '0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
      end else if (tmo_hit) begin
         // Abandon the slave side and report the timeout as a normal response.
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= 1'b1;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b11;
         state         <= ST_RSP;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cmd_q.addr  <= cmd_addr;
                  cmd_q.wdata <= cmd_wdata;
                  cmd_q.wstrb <= cmd_wstrb;
                  cmd_ready   <= 1'b0;
                  aw_done     <= 1'b0;
                  w_done      <= 1'b0;
                  if (cmd_write) begin
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= ST_WR_REQ;
                  end else begin
                     m_axi_arvalid <= 1'b1;
                     state         <= ST_RD_REQ;
                  end
               end
            end

            ST_WR_REQ: begin
               // AW and W complete independently, in either order or together.
               if (aw_hs) begin
                  m_axi_awvalid <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (w_hs) begin
                  m_axi_wvalid <= 1'b0;
                  w_done       <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  m_axi_bready <= 1'b1;
                  state        <= ST_WR_RESP;
               end
            end

            ST_WR_RESP: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  rsp_rdata    <= '0;
                  rsp_resp     <= m_axi_bresp;
                  rsp_valid    <= 1'b1;
                  state        <= ST_RSP;
               end
            end

            ST_RD_REQ: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= ST_RD_DATA;
               end
            end

            ST_RD_DATA: begin
               if (m_axi_rvalid) begin
                  m_axi_rready <= 1'b0;
                  rsp_rdata    <= m_axi_rdata;
                  rsp_resp     <= m_axi_rresp;
                  rsp_valid    <= 1'b1;
                  state        <= ST_RSP;
               end
            end

            ST_RSP: begin
               // cmd_ready returns the cycle after the response is taken.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
